key_stream_reader: RTL and testbench

- Read side of the PMU key path: captures the full key held in key storage on request and delivers it to a downstream consumer (decryptor or key-expansion logic) as a sequence of narrow words.
- Uses a valid/ready handshake; words are sent MSB-first.
- Zeroizes its internal copy of the key after delivery and rejects an all-zero (never-programmed) key.

---
 rtl/key_stream_reader.sv | 133 +++++++++++++
 tb/tb_key_stream_reader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/key_stream_reader.sv
// Key readout: captures the stored key on request and streams it MSB-first as
// WORD_WIDTH words over valid/ready. Optional lock-after-first-read: KEY_READ_ONCE_EN.
module key_stream_reader #(
  parameter int unsigned KEY_LENGTH = 128,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_LENGTH-1:0] key_data_in,
  input  logic                  key_req,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  key_err
);

  localparam int unsigned NUM_WORDS = KEY_LENGTH / WORD_WIDTH;
  localparam int unsigned CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  generate
    if ((KEY_LENGTH % WORD_WIDTH) != 0) begin : g_bad_width
      $error("key_stream_reader: KEY_LENGTH must be a multiple of WORD_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  state_e                state_q, state_d;
  logic [KEY_LENGTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] word_out_q, word_out_d;
  logic                  word_valid_q, word_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  key_err_q, key_err_d;
  logic                  locked_c;
  logic                  enter_done_c;

`ifdef KEY_READ_ONCE_EN
  logic read_lock_q;

  // Sticky lock: set on the first completed readout, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_lock_q <= 1'b0;
    end else if (enter_done_c) begin
      read_lock_q <= 1'b1;
    end
  end

  assign locked_c = read_lock_q;
`else
  assign locked_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      key_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      key_err_q    <= key_err_d;
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    key_err_d    = 1'b0;
    enter_done_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_req) begin
          if ((key_data_in == '0) || locked_c) begin
            key_err_d = 1'b1;
          end else begin
            shreg_d = key_data_in;
            cnt_d   = '0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (word_ready) begin
          shreg_d = shreg_q << WORD_WIDTH;
          if (cnt_q == CNT_W'(NUM_WORDS - 1)) begin
            cnt_d        = '0;
            state_d      = DONE;
            enter_done_c = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The word bus is forced to zero outside SEND so no key bits linger.
    word_valid_d = (state_d == SEND);
    word_out_d   = (state_d == SEND) ? shreg_d[KEY_LENGTH-1 -: WORD_WIDTH] : '0;
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign key_err    = key_err_q;

endmodule

// File: tb/tb_key_stream_reader.sv
// Bench for key_stream_reader: directed scenarios plus randomized keys/backpressure,
// checked against a word-slicing reference model of the key.
module tb_key_stream_reader;

  localparam int KL = 128;
  localparam int WW = 32;
  localparam int NW = KL / WW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [KL-1:0] key_data_in = '0;
  logic          key_req = 1'b0;
  logic [WW-1:0] word_out;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          key_err;

  int tests  = 0;
  int failed = 0;
  int reads_done = 0;

  key_stream_reader #(.KEY_LENGTH(KL), .WORD_WIDTH(WW)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_data_in(key_data_in),
    .key_req    (key_req),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .done       (done),
    .key_err    (key_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 128'(word_valid), 128'(0));
    check({tag, "_word"},  128'(word_out),   128'(0));
    check({tag, "_busy"},  128'(busy),       128'(0));
    check({tag, "_done"},  128'(done),       128'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_req = 1'b0;
    word_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [KL-1:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom} | KL'(1);
  endfunction

  // Request refused: one key_err pulse, no words, never busy.
  task automatic expect_reject(input string tag, input logic [KL-1:0] key);
    key_data_in = key;
    key_req = 1'b1;
    tick();
    key_req = 1'b0;
    check({tag, "_err"}, 128'(key_err), 128'(1));
    check_quiet(tag);
    tick();
    check({tag, "_err_end"}, 128'(key_err), 128'(0));
    check_quiet({tag, "_after"});
  endtask

  // Under the read-once build, prove the lock then clear it with reset.
  task automatic prep();
`ifdef KEY_READ_ONCE_EN
    if (reads_done > 0) expect_reject("locked", rand_key());
    do_reset();
`endif
  endtask

  // mode 0: ready always 1; mode 1: fixed 1,0,0,1,0,1,1; mode 2: random ready,
  // key churn and spurious key_req while streaming.
  task automatic do_read(input string tag, input logic [KL-1:0] key, input int mode);
    logic [WW-1:0] exp_q[$];
    bit            pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    int            idx, stalls, busy_cyc, guard;
    bit            r;
    for (int i = 0; i < NW; i++) exp_q.push_back(WW'(key >> (KL - (i + 1) * WW)));
    key_data_in = key;
    key_req = 1'b1;
    word_ready = 1'b0;
    tick();
    key_req = 1'b0;
    idx = 0; stalls = 0; busy_cyc = 0; guard = 0;
    while (idx < NW && guard < 200) begin
      check({tag, "_valid"}, 128'(word_valid), 128'(1));
      check({tag, "_word"},  128'(word_out),   128'(exp_q[idx]));
      check({tag, "_busy"},  128'(busy),       128'(1));
      check({tag, "_nodone"}, 128'(done),      128'(0));
      check({tag, "_noerr"}, 128'(key_err),    128'(0));
      busy_cyc++;
      case (mode)
        0:       r = 1'b1;
        1:       r = (guard < 7) ? pat[guard] : 1'b1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2) begin
        key_data_in = rand_key();
        key_req = 1'($urandom_range(0, 1));
      end
      word_ready = r;
      tick();
      if (r) idx++; else stalls++;
      guard++;
    end
    if (guard >= 200) check({tag, "_timeout"}, 128'(idx), 128'(NW));
    key_req = 1'b0;
    word_ready = 1'b0;
    check({tag, "_done"},      128'(done),       128'(1));
    check({tag, "_done_busy"}, 128'(busy),       128'(1));
    check({tag, "_done_nv"},   128'(word_valid), 128'(0));
    check({tag, "_done_word"}, 128'(word_out),   128'(0));
    check({tag, "_done_err"},  128'(key_err),    128'(0));
    busy_cyc++;
    tick();
    check_quiet({tag, "_idle"});
    check({tag, "_idle_err"},  128'(key_err),    128'(0));
    check({tag, "_busy_cyc"},  128'(busy_cyc),   128'(NW + 1 + stalls));
    if (mode == 1) check({tag, "_stalls"}, 128'(stalls), 128'(3));
    reads_done++;
  endtask

  localparam logic [KL-1:0] KEY0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  initial begin
    logic [KL-1:0] k;

    do_reset();
    check_quiet("reset");
    check("reset_err", 128'(key_err), 128'(0));

    do_read("basic", KEY0, 0);

`ifdef KEY_READ_ONCE_EN
    prep();
`else
    do_read("second", rand_key(), 0);
`endif

    prep();
    do_read("backpressure", KEY0, 1);

    expect_reject("zero_key", '0);

    // Asynchronous reset in the middle of a transfer, then a clean restart.
    prep();
    k = rand_key();
    key_data_in = k;
    key_req = 1'b1;
    tick();
    key_req = 1'b0;
    word_ready = 1'b1;
    check("mid_w0", 128'(word_out), 128'(WW'(k >> (KL - WW))));
    tick();
    check("mid_w1", 128'(word_out), 128'(WW'(k >> (KL - 2 * WW))));
    tick();
    #2 rst = 1'b1;
    #1;
    check_quiet("async_rst");
    check("async_rst_err", 128'(key_err), 128'(0));
    word_ready = 1'b0;
    #2 rst = 1'b0;
    tick();
    check_quiet("post_rst");
    reads_done = 0;
    do_read("restart", rand_key(), 0);

    for (int n = 0; n < 6; n++) begin
      prep();
      do_read("random", rand_key(), 2);
    end

`ifdef KEY_READ_ONCE_EN
    expect_reject("locked_final", rand_key());
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
